// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and the priority helper for the interrupt dispatcher.
package irq_pkg;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = 2;
  localparam int LOST_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Index 0 is the highest priority, so the lowest set bit wins.
  function automatic logic [ID_W-1:0] lowest_index(input logic [NUM_SRC-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector: rise is high when d is high now and was low at the previous edge.
module irq_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic hist_q;

  // History clears on reset so a level held across reset release reads as a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= d;
    end
  end

  assign rise = d & ~hist_q;

endmodule

// File: rtl/irq_dispatcher.sv
// Latches interrupt events as pending bits and hands them to the CPU one at a time,
// lowest enabled index first, through a REQ/ack and SERVICE/done handshake.
module irq_dispatcher
  import irq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 irq_valid,
  input  logic [ID_W-1:0]      irq_id,
  input  logic [NUM_SRC-1:0]   irq_mask,
  output logic                 cpu_intr,
  output logic [ID_W-1:0]      cpu_vector,
  input  logic                 cpu_ack,
  input  logic                 cpu_done,
  output logic [NUM_SRC-1:0]   src_clear,
  output logic [NUM_SRC-1:0]   pending,
  output logic                 busy,
  output logic [LOST_W-1:0]    lost_cnt
);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   src_clear_q, src_clear_d;
  logic [ID_W-1:0]      vector_q, vector_d;
  logic [LOST_W-1:0]    lost_q, lost_d;

  logic                 event_w;
  logic                 ack_take;
  logic                 lost_inc;
  logic [NUM_SRC-1:0]   set_vec;
  logic [NUM_SRC-1:0]   clr_vec;
  logic [NUM_SRC-1:0]   enabled;

  irq_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (irq_valid),
    .rise (event_w)
  );

  assign ack_take = (state_q == REQ) && cpu_ack;
  assign enabled  = pending_q & irq_mask;

  // A set on the same edge as a clear of that bit wins.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign set_vec[gi]   = event_w && (irq_id == ID_W'(gi));
    assign clr_vec[gi]   = ack_take && (vector_q == ID_W'(gi));
    assign pending_d[gi] = set_vec[gi] | (pending_q[gi] & ~clr_vec[gi]);
  end

  // A colliding set/clear is not a lost request: the bit was about to be freed.
  assign lost_inc = event_w && pending_q[irq_id] && !clr_vec[irq_id];

  always_comb begin
    lost_d = lost_q;
    if (lost_inc && (lost_q != {LOST_W{1'b1}})) begin
      lost_d = lost_q + LOST_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    vector_d    = vector_q;
    src_clear_d = '0;
    unique case (state_q)
      IDLE: begin
        if (|enabled) begin
          state_d  = REQ;
          vector_d = lowest_index(enabled);
        end
      end
      REQ: begin
        if (cpu_ack) begin
          state_d     = SERVICE;
          src_clear_d = clr_vec;
        end
      end
      SERVICE: begin
        if (cpu_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      src_clear_q <= '0;
      vector_q    <= '0;
      lost_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      src_clear_q <= src_clear_d;
      vector_q    <= vector_d;
      lost_q      <= lost_d;
    end
  end

  assign cpu_intr   = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign cpu_vector = vector_q;
  assign src_clear  = src_clear_q;
  assign pending    = pending_q;
  assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Directed bench for irq_dispatcher: single event, priority order, masking, lost-count
// saturation, reset during service and the set/clear collision.
module tb_irq_dispatcher;

  logic       clk;
  logic       rst;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [3:0] irq_mask;
  logic       cpu_intr;
  logic [1:0] cpu_vector;
  logic       cpu_ack;
  logic       cpu_done;
  logic [3:0] src_clear;
  logic [3:0] pending;
  logic       busy;
  logic [7:0] lost_cnt;

  int vectors;
  int miscompares;

  irq_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_mask   (irq_mask),
    .cpu_intr   (cpu_intr),
    .cpu_vector (cpu_vector),
    .cpu_ack    (cpu_ack),
    .cpu_done   (cpu_done),
    .src_clear  (src_clear),
    .pending    (pending),
    .busy       (busy),
    .lost_cnt   (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One event edge followed by one low edge so the next pulse is a fresh rise.
  task automatic pulse(input logic [1:0] id);
    irq_id    = id;
    irq_valid = 1'b1;
    tick();
    irq_valid = 1'b0;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    irq_valid = 1'b0;
    irq_id    = 2'd0;
    irq_mask  = 4'hF;
    cpu_ack   = 1'b0;
    cpu_done  = 1'b0;
    tick();
    tick();
    chk("rst_intr",    cpu_intr,   0);
    chk("rst_busy",    busy,       0);
    chk("rst_pending", pending,    0);
    chk("rst_lost",    lost_cnt,   0);
    chk("rst_vector",  cpu_vector, 0);
    chk("rst_clear",   src_clear,  0);
    rst = 1'b0;
    tick();

    // Single event, id 2 held three cycles
    irq_id = 2'd2;
    irq_valid = 1'b1;
    tick();
    chk("t1_pending", pending, 4'b0100);
    chk("t1_intr_early", cpu_intr, 0);
    tick();
    chk("t1_intr", cpu_intr, 1);
    chk("t1_vector", cpu_vector, 2);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_held_lost", lost_cnt, 0);
    irq_valid = 1'b0;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t1_clear", src_clear, 4'b0100);
    chk("t1_pend_clr", pending, 0);
    chk("t1_intr_svc", cpu_intr, 0);
    chk("t1_busy_svc", busy, 1);
    tick();
    chk("t1_clear_once", src_clear, 0);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t1_done_busy", busy, 0);
    chk("t1_done_vec_hold", cpu_vector, 2);

    // Priority: 3 and 1 latched while masked, 0 arrives during service
    irq_mask = 4'h0;
    pulse(2'd3);
    pulse(2'd1);
    chk("t2_pending", pending, 4'b1010);
    chk("t2_idle", busy, 0);
    irq_mask = 4'hF;
    tick();
    chk("t2_vec1", cpu_vector, 1);
    chk("t2_intr1", cpu_intr, 1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t2_clear1", src_clear, 4'b0010);
    chk("t2_pend1", pending, 4'b1000);
    pulse(2'd0);
    chk("t2_pend_svc", pending, 4'b1001);
    chk("t2_no_nest", cpu_intr, 0);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t2_idle1", busy, 0);
    tick();
    chk("t2_vec0", cpu_vector, 0);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t2_clear0", src_clear, 4'b0001);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();
    chk("t2_vec3", cpu_vector, 3);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t2_clear3", src_clear, 4'b1000);
    chk("t2_pend_empty", pending, 0);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t2_end_busy", busy, 0);

    // Mask: id 0 held back while mask[0] = 0
    irq_mask = 4'h0;
    pulse(2'd0);
    pulse(2'd1);
    chk("t3_pending", pending, 4'b0011);
    irq_mask = 4'b1110;
    tick();
    chk("t3_vec1", cpu_vector, 1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t3_clear1", src_clear, 4'b0010);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();
    chk("t3_held_idle", busy, 0);
    chk("t3_held_pend", pending, 4'b0001);
    irq_mask = 4'hF;
    tick();
    chk("t3_vec0", cpu_vector, 0);
    irq_mask = 4'h0;
    tick();
    chk("t3_mask_in_req", cpu_intr, 1);
    irq_mask = 4'hF;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t3_clear0", src_clear, 4'b0001);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();

    // Lost count saturation: 300 duplicates of id 0 while waiting in REQ
    pulse(2'd0);
    chk("t4_req", cpu_intr, 1);
    for (int i = 0; i < 300; i++) begin
      pulse(2'd0);
      if (i == 253) chk("t4_lost254", lost_cnt, 254);
    end
    chk("t4_lost_sat", lost_cnt, 255);
    chk("t4_pend0", pending, 4'b0001);
    chk("t4_vec0", cpu_vector, 0);

    // Reset during SERVICE with irq_valid held across release
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t5_clear0", src_clear, 4'b0001);
    tick();
    rst = 1'b1;
    irq_id = 2'd2;
    irq_valid = 1'b1;
    tick();
    chk("t5_rst_intr", cpu_intr, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pend", pending, 0);
    chk("t5_rst_lost", lost_cnt, 0);
    chk("t5_rst_vec", cpu_vector, 0);
    chk("t5_rst_clear", src_clear, 0);
    rst = 1'b0;
    tick();
    chk("t5_release_evt", pending, 4'b0100);
    chk("t5_release_clear", src_clear, 0);
    tick();
    chk("t5_req_vec", cpu_vector, 2);
    chk("t5_req_intr", cpu_intr, 1);
    irq_valid = 1'b0;
    tick();

    // Collision: new id 2 event on the ack edge for vector 2
    pulse(2'd2);
    chk("t6_lost1", lost_cnt, 1);
    irq_id = 2'd2;
    irq_valid = 1'b1;
    cpu_ack = 1'b1;
    tick();
    irq_valid = 1'b0;
    cpu_ack = 1'b0;
    chk("t6_clear", src_clear, 4'b0100);
    chk("t6_pend_kept", pending, 4'b0100);
    chk("t6_lost_same", lost_cnt, 1);
    chk("t6_service", busy, 1);
    tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();
    chk("t6_rerequest", cpu_intr, 1);
    chk("t6_revec", cpu_vector, 2);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("t6_final_pend", pending, 0);
    chk("t6_final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
